// File: rtl/event_reader_pkg.sv
// ============================================================================
// event_reader_pkg : constants, event type and reader FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package event_reader_pkg;

    // Shared with the event writer: burst length and word width must match.
    localparam int WORDS_PER_EVENT = 16;
    localparam int WORD_WIDTH      = 64;
    localparam int WORD_IDX_WIDTH  = $clog2(WORDS_PER_EVENT);
    localparam int WORD_CNT_WIDTH  = $clog2(WORDS_PER_EVENT + 1);

    typedef logic [WORDS_PER_EVENT-1:0][WORD_WIDTH-1:0] event_t;
    typedef logic [WORD_CNT_WIDTH-1:0]                  word_cnt_t;

    localparam word_cnt_t WORDS_FULL = word_cnt_t'(WORDS_PER_EVENT);
    localparam word_cnt_t WORDS_LAST = word_cnt_t'(WORDS_PER_EVENT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READING = 2'd1,
        VALID   = 2'd2
    } reader_state_t;

endpackage

`default_nettype wire

// File: rtl/event_reader_timeout.sv
// ============================================================================
// event_reader_timeout : starve counter, expires after TIMEOUT_CYCLES incs
// Rev 1.0
// ============================================================================
`default_nettype none

module event_reader_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] c_last = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [CNT_WIDTH-1:0] count_q;

    // Expires on the TIMEOUT_CYCLES-th consecutive increment and self-clears.
    assign expired_o = inc_i && (count_q == c_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear_i || expired_o) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + CNT_WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/event_reader.sv
// ============================================================================
// event_reader : pops WORDS_PER_EVENT FIFO words and presents one event
// Rev 1.0
// ============================================================================
`default_nettype none

module event_reader
    import event_reader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   empty_i,
    input  logic [WORD_WIDTH-1:0]  dout_i,
    output logic                   rd_en_o,
    output event_t                 event_o,
    output logic                   event_valid_o,
    input  logic                   event_ready_i,
    output logic [COUNT_WIDTH-1:0] event_count_o,
    output logic                   timeout_o
);

    reader_state_t          state_q, state_d;
    word_cnt_t              issued_q, issued_d;
    word_cnt_t              received_q, received_d;
    event_t                 event_q, event_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   rd_q;

    logic                   w_rd_en;
    logic                   w_starved;
    logic                   w_expired;

    assign w_starved = (state_q == READING) && !rd_q;

    event_reader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (!w_starved),
        .inc_i     (w_starved),
        .expired_o (w_expired)
    );

    // Blocked in the timeout cycle so nothing is left in flight on the drop;
    // blocked under reset so every output reads 0 while rst is high.
    assign w_rd_en = !rst
                   && ((state_q == IDLE) || (state_q == READING))
                   && !empty_i
                   && (issued_q != WORDS_FULL)
                   && !w_expired;

    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        received_d = received_q;
        event_d    = event_q;
        count_d    = count_q;

        if (w_rd_en) begin
            issued_d = issued_q + word_cnt_t'(1);
        end

        if (rd_q) begin
            event_d[received_q[WORD_IDX_WIDTH-1:0]] = dout_i;
            received_d = received_q + word_cnt_t'(1);
        end

        case (state_q)
            IDLE: begin
                if (w_rd_en) begin
                    state_d = READING;
                end
            end
            READING: begin
                if (rd_q && (received_q == WORDS_LAST)) begin
                    state_d    = VALID;
                    issued_d   = '0;
                    received_d = '0;
                end else if (w_expired) begin
                    state_d    = IDLE;
                    issued_d   = '0;
                    received_d = '0;
                end
            end
            VALID: begin
                if (event_ready_i) begin
                    count_d = count_q + COUNT_WIDTH'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            issued_q   <= '0;
            received_q <= '0;
            event_q    <= '0;
            count_q    <= '0;
            rd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            event_q    <= event_d;
            count_q    <= count_d;
            rd_q       <= w_rd_en;
        end
    end

    assign rd_en_o       = w_rd_en;
    assign event_o       = event_q;
    assign event_valid_o = (state_q == VALID);
    assign event_count_o = count_q;
    assign timeout_o     = w_expired;

endmodule

`default_nettype wire

// File: tb/tb_event_reader.sv
// ============================================================================
// tb_event_reader : directed self-checking bench for event_reader
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_event_reader;
    import event_reader_pkg::*;

    localparam int TIMEOUT_CYCLES = 8;
    localparam int COUNT_WIDTH    = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   empty_i;
    logic [63:0]            dout_i;
    logic                   rd_en_o;
    event_t                 event_o;
    logic                   event_valid_o;
    logic                   event_ready_i;
    logic [COUNT_WIDTH-1:0] event_count_o;
    logic                   timeout_o;

    int checks   = 0;
    int failures = 0;

    // FIFO model: 1-cycle read latency, pointers wrap at 256
    logic [63:0] mem [0:255];
    logic [7:0]  wr_ptr;
    logic [7:0]  rd_ptr;
    logic        hold_empty;
    logic        flush;

    assign empty_i = (wr_ptr == rd_ptr) || hold_empty;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (rd_en_o) begin
            dout_i <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 8'd1;
        end
    end

    event_reader #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .COUNT_WIDTH    (COUNT_WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .empty_i       (empty_i),
        .dout_i        (dout_i),
        .rd_en_o       (rd_en_o),
        .event_o       (event_o),
        .event_valid_o (event_valid_o),
        .event_ready_i (event_ready_i),
        .event_count_o (event_count_o),
        .timeout_o     (timeout_o)
    );

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic push_event(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) push(base + 64'(i));
    endtask

    function automatic event_t make_ev(input logic [63:0] base);
        event_t ev;
        for (int i = 0; i < WORDS_PER_EVENT; i++) ev[i] = base + 64'(i);
        return ev;
    endfunction

    function automatic int first_diff(input event_t a, input event_t b);
        for (int i = 0; i < WORDS_PER_EVENT; i++) if (a[i] !== b[i]) return i;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ev(input string tag, input event_t obs, input event_t exp);
        int k;
        checks++;
        assert (obs === exp) else begin
            failures++;
            k = first_diff(obs, exp);
            $error("FAIL %s: word %0d observed=%0h expected=%0h", tag, k, obs[k], exp[k]);
        end
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (!event_valid_o && n < max_cyc) begin
            tick();
            n++;
        end
        chk(tag, event_valid_o, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [COUNT_WIDTH-1:0] exp_count;
        logic                   seen;
        int                     pulses;
        int                     first_pulse;
        logic [63:0]            base;

        rst           = 1'b1;
        flush         = 1'b1;
        hold_empty    = 1'b0;
        event_ready_i = 1'b0;
        wr_ptr        = 8'd0;
        exp_count     = '0;
        tick();
        tick();
        flush = 1'b0;
        chk("reset_rd_en", rd_en_o, 1'b0);
        chk("reset_valid", event_valid_o, 1'b0);
        chk("reset_count", 64'(event_count_o), 64'd0);
        chk("reset_timeout", timeout_o, 1'b0);
        chk_ev("reset_event", event_o, '0);
        tick();
        rst = 1'b0;

        // Test 1: continuous FIFO, consumer always ready
        tick();
        event_ready_i = 1'b1;
        push_event(64'h1000, 16);
        #1;
        for (int c = 0; c < 16; c++) begin
            chk($sformatf("t1_rd_en_c%0d", c), rd_en_o, 1'b1);
            tick();
        end
        chk("t1_rd_en_c16", rd_en_o, 1'b0);
        chk("t1_valid_c16", event_valid_o, 1'b0);
        tick();
        chk("t1_valid_c17", event_valid_o, 1'b1);
        chk_ev("t1_event", event_o, make_ev(64'h1000));
        chk("t1_word0", event_o[0], 64'h1000);
        chk("t1_word15", event_o[15], 64'h100F);
        tick();
        exp_count++;
        chk("t1_valid_drop", event_valid_o, 1'b0);
        chk("t1_count", 64'(event_count_o), 64'(exp_count));

        // Test 2: 5-cycle empty gap after word 7
        tick();
        push_event(64'h1000, 16);
        #1;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("t2_rd_en_c%0d", c), rd_en_o, 1'b1);
            tick();
        end
        hold_empty = 1'b1;
        #1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t2_gap_rd_en_%0d", c), rd_en_o, 1'b0);
            seen = seen | timeout_o;
            tick();
        end
        hold_empty = 1'b0;
        #1;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("t2_rd_en_c%0d", c + 13), rd_en_o, 1'b1);
            seen = seen | timeout_o;
            tick();
        end
        chk("t2_valid_c21", event_valid_o, 1'b0);
        tick();
        chk("t2_valid_c22", event_valid_o, 1'b1);
        chk_ev("t2_event", event_o, make_ev(64'h1000));
        chk("t2_no_timeout", seen, 1'b0);
        tick();
        exp_count++;
        chk("t2_count", 64'(event_count_o), 64'(exp_count));

        // Test 3: consumer stalls 20 cycles with 32 words queued
        event_ready_i = 1'b0;
        push_event(64'h2000, 32);
        #1;
        wait_valid("t3_valid", 30);
        chk_ev("t3_event", event_o, make_ev(64'h2000));
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("t3_hold_valid_%0d", c), event_valid_o, 1'b1);
            chk($sformatf("t3_hold_rd_en_%0d", c), rd_en_o, 1'b0);
            chk_ev($sformatf("t3_hold_event_%0d", c), event_o, make_ev(64'h2000));
        end
        event_ready_i = 1'b1;
        tick();
        exp_count++;
        chk("t3_valid_drop", event_valid_o, 1'b0);
        chk("t3_count1", 64'(event_count_o), 64'(exp_count));
        chk("t3_rd_en_resume", rd_en_o, 1'b1);
        wait_valid("t3_valid2", 30);
        chk_ev("t3_event2", event_o, make_ev(64'h2010));
        tick();
        exp_count++;
        chk("t3_count2", 64'(event_count_o), 64'(exp_count));

        // Test 4: only 9 words, partial event times out
        push_event(64'h3000, 9);
        #1;
        pulses      = 0;
        first_pulse = -1;
        seen        = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (timeout_o) begin
                if (pulses == 0) first_pulse = c;
                pulses++;
            end
            seen = seen | event_valid_o;
            tick();
        end
        chk("t4_pulses", 64'(pulses), 64'd1);
        chk("t4_pulse_cycle", 64'(first_pulse), 64'd17);
        chk("t4_no_valid", seen, 1'b0);
        push_event(64'h4000, 16);
        #1;
        wait_valid("t4_valid_after", 30);
        chk_ev("t4_event_after", event_o, make_ev(64'h4000));
        tick();
        exp_count++;
        chk("t4_count", 64'(event_count_o), 64'(exp_count));

        // Test 5: asynchronous reset after 6 words
        push_event(64'h5000, 16);
        #1;
        for (int c = 0; c < 6; c++) tick();
        chk("t5_pre_word0", event_o[0], 64'h5000);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_rd_en", rd_en_o, 1'b0);
        chk("t5_rst_valid", event_valid_o, 1'b0);
        chk("t5_rst_count", 64'(event_count_o), 64'd0);
        chk("t5_rst_timeout", timeout_o, 1'b0);
        chk_ev("t5_rst_event", event_o, '0);
        flush = 1'b1;
        tick();
        tick();
        flush     = 1'b0;
        rst       = 1'b0;
        exp_count = '0;
        tick();
        push_event(64'h6000, 16);
        #1;
        wait_valid("t5_valid_after", 30);
        chk_ev("t5_event_after", event_o, make_ev(64'h6000));
        tick();
        exp_count++;
        chk("t5_count", 64'(event_count_o), 64'(exp_count));

        // Test 6: 17 events from reset, counter wraps 15 -> 0 -> 1
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        exp_count = '0;
        for (int e = 0; e < 17; e++) begin
            tick();
            base = 64'h7000 + 64'(e * 16);
            push_event(base, 16);
            #1;
            wait_valid($sformatf("t6_valid_e%0d", e), 30);
            chk_ev($sformatf("t6_event_e%0d", e), event_o, make_ev(base));
            tick();
            exp_count++;
            chk($sformatf("t6_count_e%0d", e), 64'(event_count_o), 64'(exp_count));
        end
        chk("t6_final_count", 64'(event_count_o), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
